// File: rtl/sd_spi_pkg.sv
// SD-card SPI slave shared types and constants.
// Used by the response transmitter and the data-block CRC unit.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NCR,
        RESP,
        GAP,
        TOKEN,
        DATA,
        CRC,
        DONE
    } state_t;

    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam logic [7:0]  FILL_BYTE   = 8'hFF;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

endpackage

// File: rtl/spi_slave_transmitter_if.sv
// Request, payload and serial-line signals of the SPI response transmitter.
// slave is the transmitter side, master is the controller/host side.
interface spi_slave_transmitter_if;

    logic        io_SpiClk;
    logic        io_Cs;
    logic        io_Do;
    logic        io_RespValid;
    logic        io_RespLong;
    logic [39:0] io_RespData;
    logic        io_WithData;
    logic [31:0] io_DataBlockSize;
    logic [7:0]  io_DataByte;
    logic        io_DataValid;
    logic        io_DataReady;
    logic        io_Busy;
    logic        io_Done;
    logic        io_Aborted;
    logic        io_Underrun;

    modport slave (
        input  io_SpiClk, io_Cs, io_RespValid, io_RespLong, io_RespData,
        input  io_WithData, io_DataBlockSize, io_DataByte, io_DataValid,
        output io_Do, io_DataReady, io_Busy, io_Done, io_Aborted, io_Underrun
    );

    modport master (
        output io_SpiClk, io_Cs, io_RespValid, io_RespLong, io_RespData,
        output io_WithData, io_DataBlockSize, io_DataByte, io_DataValid,
        input  io_Do, io_DataReady, io_Busy, io_Done, io_Aborted, io_Underrun
    );

endinterface

// File: rtl/sd_crc16_byte.sv
// Combinational CRC16-CCITT (0x1021) update of one byte, MSB first.
// No reflection and no final XOR; shared with the data-block receiver.
module sd_crc16_byte
    import sd_spi_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ byte_in[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC16_POLY;
        end
        crc_out = c;
    end

endmodule

// File: rtl/spi_slave_transmitter.sv
// SD SPI response transmitter: Ncr filler, R1/R3/R7 response and an
// optional data block, shifted MSB first on DO after each SCK fall.
module spi_slave_transmitter
    import sd_spi_pkg::*;
#(
    parameter int NCR_BYTES   = 1,
    parameter int NAC_BYTES   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    spi_slave_transmitter_if.slave bus
);

    localparam logic [7:0] NCR_LAST = 8'(NCR_BYTES - 1);
    localparam logic [7:0] NAC_LAST = 8'(NAC_BYTES - 1);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic sck_s, sck_d, cs_s, cs_d;
    logic sck_fall, cs_rise;

    state_t      state, state_n;
    logic [7:0]  sh;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [31:0] rem_q;
    logic [15:0] crc_q, crc_nx;
    logic [39:0] resp_q;
    logic        long_q, with_q;
    logic [31:0] size_q;
    logic        underrun_q, aborted_q;

    logic       ld, shift, cnt_clr, cnt_inc;
    logic [7:0] ld_val;
    logic       rem_ld, rem_dec, crc_clr, crc_upd, resp_sh;
    logic       take, urun, accept, abort;
    logic [7:0] tx_byte;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_fall = sck_d & ~sck_s;
    assign cs_rise  = ~cs_d & cs_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.io_SpiClk};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.io_Cs};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    // Missing payload is replaced by filler, and the filler is what gets CRC'd
    assign tx_byte = bus.io_DataValid ? bus.io_DataByte : FILL_BYTE;

    sd_crc16_byte u_crc (
        .crc_in  (crc_q),
        .byte_in (tx_byte),
        .crc_out (crc_nx)
    );

    always_comb begin
        state_n = state;
        ld      = 1'b0;
        ld_val  = FILL_BYTE;
        shift   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        rem_ld  = 1'b0;
        rem_dec = 1'b0;
        crc_clr = 1'b0;
        crc_upd = 1'b0;
        resp_sh = 1'b0;
        take    = 1'b0;
        urun    = 1'b0;
        accept  = 1'b0;
        abort   = 1'b0;
        if (state != IDLE && cs_rise) begin
            abort   = 1'b1;
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.io_RespValid && !cs_s) begin
                        accept  = 1'b1;
                        state_n = NCR;
                    end
                end
                DONE: state_n = IDLE;
                default: begin
                    if (sck_fall && bit_cnt != 3'd7) begin
                        shift = 1'b1;
                    end else if (sck_fall) begin
                        ld = 1'b1;
                        unique case (state)
                            NCR: begin
                                if (byte_cnt == NCR_LAST) begin
                                    state_n = RESP;
                                    ld_val  = resp_q[39:32];
                                    resp_sh = 1'b1;
                                    cnt_clr = 1'b1;
                                end else begin
                                    cnt_inc = 1'b1;
                                end
                            end
                            RESP: begin
                                if (!long_q || byte_cnt == 8'd4) begin
                                    state_n = with_q ? GAP : DONE;
                                    cnt_clr = 1'b1;
                                end else begin
                                    ld_val  = resp_q[39:32];
                                    resp_sh = 1'b1;
                                    cnt_inc = 1'b1;
                                end
                            end
                            GAP: begin
                                if (byte_cnt == NAC_LAST) begin
                                    state_n = TOKEN;
                                    ld_val  = START_TOKEN;
                                    crc_clr = 1'b1;
                                end else begin
                                    cnt_inc = 1'b1;
                                end
                            end
                            TOKEN, DATA: begin
                                if ((state == TOKEN) ? (size_q != '0)
                                                     : (rem_q != '0)) begin
                                    state_n = DATA;
                                    ld_val  = tx_byte;
                                    crc_upd = 1'b1;
                                    take    = bus.io_DataValid;
                                    urun    = ~bus.io_DataValid;
                                    rem_ld  = (state == TOKEN);
                                    rem_dec = (state == DATA);
                                end else begin
                                    state_n = CRC;
                                    ld_val  = crc_q[15:8];
                                    cnt_clr = 1'b1;
                                end
                            end
                            CRC: begin
                                if (byte_cnt == 8'd0) begin
                                    ld_val  = crc_q[7:0];
                                    cnt_inc = 1'b1;
                                end else begin
                                    state_n = DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= FILL_BYTE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            rem_q      <= '0;
            crc_q      <= '0;
            resp_q     <= '0;
            long_q     <= 1'b0;
            with_q     <= 1'b0;
            size_q     <= '0;
            underrun_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state     <= state_n;
            aborted_q <= abort;
            if (accept) begin
                sh      <= FILL_BYTE;
                bit_cnt <= '0;
                long_q  <= bus.io_RespLong;
                with_q  <= bus.io_WithData;
                size_q  <= bus.io_DataBlockSize;
            end else if (shift) begin
                sh      <= {sh[6:0], 1'b1};
                bit_cnt <= bit_cnt + 3'd1;
            end else if (ld) begin
                sh      <= ld_val;
                bit_cnt <= '0;
            end
            // R1 is left-aligned so every response byte comes from [39:32]
            if (accept)
                resp_q <= bus.io_RespLong ? bus.io_RespData
                                          : {bus.io_RespData[7:0], 32'h0};
            else if (resp_sh)
                resp_q <= {resp_q[31:0], 8'h00};
            if (accept || cnt_clr)
                byte_cnt <= '0;
            else if (cnt_inc)
                byte_cnt <= byte_cnt + 8'd1;
            if (rem_ld)
                rem_q <= size_q - 32'd1;
            else if (rem_dec)
                rem_q <= rem_q - 32'd1;
            if (crc_clr)
                crc_q <= '0;
            else if (crc_upd)
                crc_q <= crc_nx;
            if (accept)
                underrun_q <= 1'b0;
            else if (urun)
                underrun_q <= 1'b1;
        end
    end

    assign bus.io_Do        = (state == IDLE || state == DONE) ? 1'b1 : sh[7];
    assign bus.io_Busy      = (state != IDLE);
    assign bus.io_Done      = (state == DONE) && !abort;
    assign bus.io_Aborted   = aborted_q;
    assign bus.io_DataReady = take;
    assign bus.io_Underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave_transmitter.sv
// Directed bench for the SD SPI response transmitter acting as SPI host.
// Table of request records plus underrun, abort and reset sequences.
module tb_spi_slave_transmitter;

    localparam int HALF = 4;
    localparam int SYNC = 2;

    typedef struct {
        logic        lng;
        logic [39:0] d;
        logic        wd;
        logic [31:0] sz;
        int          mode;
        logic [15:0] crc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_transmitter_if bus();

    spi_slave_transmitter #(
        .NCR_BYTES   (1),
        .NAC_BYTES   (1),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int ready_cnt = 0;
    int abort_cnt = 0;
    int pay_base = 0;
    int pay_mode = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    vec_t tbl[5];

    function automatic logic [7:0] pay(int idx, int mode);
        return (mode == 0) ? 8'hFF : 8'(18 + idx * 34);
    endfunction

    function automatic logic [15:0] crc_model(int n, int mode, logic valid);
        logic [15:0] c = 16'h0;
        logic [7:0] b;
        logic fb;
        for (int i = 0; i < n; i++) begin
            b = valid ? pay(i, mode) : 8'hFF;
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ b[k];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Byte presented is updated before counting, so it holds across the load edge
    always @(negedge clk) begin
        bus.io_DataByte = pay(ready_cnt - pay_base, pay_mode);
        if (bus.io_Done) done_cnt++;
        if (bus.io_Aborted) abort_cnt++;
        if (bus.io_DataReady) ready_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic rx_bits(input int nbits);
        logic [7:0] cur = 8'h0;
        for (int i = 0; i < nbits; i++) begin
            bus.io_SpiClk = 1'b1;
            repeat (HALF) @(negedge clk);
            cur = {cur[6:0], bus.io_Do};
            bus.io_SpiClk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i % 8 == 7) got.push_back(cur);
        end
    endtask

    task automatic build_exp(input vec_t v, input logic valid);
        exp_q = {};
        exp_q.push_back(8'hFF);
        if (v.lng) begin
            exp_q.push_back(v.d[39:32]);
            exp_q.push_back(v.d[31:24]);
            exp_q.push_back(v.d[23:16]);
            exp_q.push_back(v.d[15:8]);
            exp_q.push_back(v.d[7:0]);
        end else begin
            exp_q.push_back(v.d[7:0]);
        end
        if (v.wd) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            for (int i = 0; i < int'(v.sz); i++)
                exp_q.push_back(valid ? pay(i, v.mode) : 8'hFF);
            exp_q.push_back(v.crc[15:8]);
            exp_q.push_back(v.crc[7:0]);
        end
    endtask

    task automatic cmp_stream(input string name, input int n);
        int nerr = 0;
        int first = -1;
        for (int i = 0; i < n; i++) begin
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        chk({name, "_stream_errs"}, 64'(nerr), 64'd0);
        if (nerr != 0)
            $display("  first bad byte %0d of %0d", first, n);
    endtask

    task automatic request(input vec_t v, input logic valid);
        pay_base = ready_cnt;
        pay_mode = v.mode;
        bus.io_DataValid = valid;
        @(negedge clk);
        bus.io_RespValid     = 1'b1;
        bus.io_RespLong      = v.lng;
        bus.io_RespData      = v.d;
        bus.io_WithData      = v.wd;
        bus.io_DataBlockSize = v.sz;
        @(negedge clk);
        bus.io_RespValid = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v, input logic valid,
                           input logic exp_urun);
        int d0 = done_cnt;
        int r0 = ready_cnt;
        build_exp(v, valid);
        got = {};
        request(v, valid);
        chk({name, "_busy"}, 64'(bus.io_Busy), 64'd1);
        chk({name, "_urun_clr"}, 64'(bus.io_Underrun), 64'd0);
        rx_bits(8 * exp_q.size());
        repeat (3) @(negedge clk);
        cmp_stream(name, exp_q.size());
        chk({name, "_done"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_ready"}, 64'(ready_cnt - r0),
            (v.wd && valid) ? 64'(v.sz) : 64'd0);
        chk({name, "_urun"}, 64'(bus.io_Underrun), 64'(exp_urun));
        chk({name, "_idle"}, 64'(bus.io_Busy), 64'd0);
        chk({name, "_do"}, 64'(bus.io_Do), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int d0, a0, r0;
        vec_t v;
        bus.io_SpiClk = 1'b0;
        bus.io_Cs = 1'b1;
        bus.io_RespValid = 1'b0;
        bus.io_RespLong = 1'b0;
        bus.io_RespData = '0;
        bus.io_WithData = 1'b0;
        bus.io_DataBlockSize = '0;
        bus.io_DataValid = 1'b0;

        tbl[0] = '{1'b0, 40'h01, 1'b0, 32'd0, 0, 16'h0000};
        tbl[1] = '{1'b1, 40'h01000001AA, 1'b0, 32'd0, 0, 16'h0000};
        tbl[2] = '{1'b0, 40'h00, 1'b1, 32'd512, 0, 16'h7FA1};
        tbl[3] = '{1'b0, 40'h00, 1'b1, 32'd0, 0, 16'h0000};
        tbl[4] = '{1'b1, 40'hC0FF800000, 1'b1, 32'd4, 1,
                   crc_model(4, 1, 1'b1)};

        repeat (3) @(negedge clk);
        chk("rst_do", 64'(bus.io_Do), 64'd1);
        chk("rst_busy", 64'(bus.io_Busy), 64'd0);
        chk("rst_done", 64'(bus.io_Done), 64'd0);
        chk("rst_abort", 64'(bus.io_Aborted), 64'd0);
        chk("rst_ready", 64'(bus.io_DataReady), 64'd0);
        chk("rst_urun", 64'(bus.io_Underrun), 64'd0);
        rst = 1'b0;
        bus.io_Cs = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_vec($sformatf("vec%0d", i), tbl[i], 1'b1, 1'b0);

        // Payload never valid: filler bytes sent, CRC over two 0xFF bytes
        v = '{1'b0, 40'h00, 1'b1, 32'd2, 0, crc_model(2, 0, 1'b0)};
        run_vec("urun", v, 1'b0, 1'b1);
        run_vec("urun_next", tbl[0], 1'b1, 1'b0);

        // CS rises partway through the third payload byte
        v = '{1'b0, 40'h00, 1'b1, 32'd8, 1, 16'h0};
        build_exp(v, 1'b1);
        got = {};
        d0 = done_cnt;
        a0 = abort_cnt;
        r0 = ready_cnt;
        request(v, 1'b1);
        rx_bits(8 * 6 + 3);
        cmp_stream("abort_pre", 6);
        @(negedge clk);
        bus.io_Cs = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        chk("abort_do", 64'(bus.io_Do), 64'd1);
        chk("abort_busy", 64'(bus.io_Busy), 64'd0);
        chk("abort_pulse", 64'(abort_cnt - a0), 64'd1);
        chk("abort_nodone", 64'(done_cnt - d0), 64'd0);
        chk("abort_ready", 64'(ready_cnt - r0), 64'd3);
        bus.io_Cs = 1'b0;
        repeat (5) @(negedge clk);
        v = '{1'b0, 40'h05, 1'b0, 32'd0, 0, 16'h0};
        run_vec("after_abort", v, 1'b1, 1'b0);

        // Reset lands in the middle of the response byte
        v = '{1'b0, 40'h33, 1'b0, 32'd0, 0, 16'h0};
        got = {};
        request(v, 1'b1);
        rx_bits(8 + 3);
        d0 = done_cnt;
        a0 = abort_cnt;
        @(negedge clk);
        chk("pre_rst_busy", 64'(bus.io_Busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_do", 64'(bus.io_Do), 64'd1);
        chk("mid_rst_busy", 64'(bus.io_Busy), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_nodone", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_noabort", 64'(abort_cnt - a0), 64'd0);
        v = '{1'b0, 40'h05, 1'b0, 32'd0, 0, 16'h0};
        run_vec("after_rst", v, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
